// File: rtl/vga_timing_gen.sv
// Pixel-clock raster timing generator: scan position, blanking, syncs and line/frame strobes.
// Optional frame counter is enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic        pix_clk,
  input  logic        rst_n,
  input  logic        locked,
  output logic [9:0]  pos_h,
  output logic [9:0]  pos_v,
  output logic        blank,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       h_wrap;
  logic       v_wrap;
  logic       frame_wrap;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       blank_next;
  logic       hs_next;
  logic       vs_next;

  // Decode on the next position so every registered output lines up with pos_h/pos_v.
  always_comb begin
    h_wrap     = (pos_h == H_LAST);
    v_wrap     = (pos_v == V_LAST);
    frame_wrap = h_wrap && v_wrap;
    h_next     = h_wrap ? 10'd0 : pos_h + 10'd1;
    v_next     = pos_v;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : pos_v + 10'd1;
    end
    blank_next = (h_next >= H_VIS) || (v_next >= V_VIS);
    hs_next    = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
    vs_next    = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_h       <= '0;
      pos_v       <= '0;
      blank       <= 1'b0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (locked) begin
      pos_h       <= h_next;
      pos_v       <= v_next;
      blank       <= blank_next;
      hsync       <= hs_next ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= vs_next ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      line_start  <= h_wrap;
      frame_start <= frame_wrap;
    end else begin
      // Lock lost: raster freezes in place, strobes suppressed until it resumes.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (locked && frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = '0;
`endif

endmodule
